break_output_gate: RTL and testbench



---
 rtl/break_output_gate.sv | 105 ++++++++++
 tb/tb_break_output_gate.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/break_output_gate.sv
// Timer output stage: main-output-enable state machine, break blanking, idle levels,
// automatic re-arm and latched break flag. All outputs are registered from the next state.
module break_output_gate #(
   parameter int unsigned CH_NUM = 3,
   parameter int unsigned DT_W   = 8
) (
   input  logic              pe_gen_clk,
   input  logic              pe_gen_rst,
   input  logic              fault_detected,
   input  logic              update_event,
   input  logic              r_moe_set,
   input  logic              r_moe_clr,
   input  logic              r_aoe,
   input  logic              r_ossi,
   input  logic [CH_NUM-1:0] r_ois,
   input  logic [CH_NUM-1:0] r_oisn,
   input  logic [DT_W-1:0]   r_bdt,
   input  logic              r_bie,
   input  logic              r_bif_clr,
   input  logic [CH_NUM-1:0] pwm_oc,
   input  logic [CH_NUM-1:0] pwm_ocn,
   output logic [CH_NUM-1:0] advtmr_oc,
   output logic [CH_NUM-1:0] advtmr_ocn,
   output logic [CH_NUM-1:0] advtmr_oc_oen,
   output logic              moe,
   output logic              bif,
   output logic              int_status_break
);

   typedef enum logic [1:0] {S_OFF, S_RUN, S_BRK_DT, S_BRK_IDLE} state_t;

   state_t          state;
   state_t          state_nx;
   logic [DT_W-1:0] cnt;
   logic            in_brk;
   logic            set_ok;
   logic            rearm;
   logic            brk_entry;
   logic            bif_nx;

   // Next state; fault entry outranks everything, clear outranks set.
   always_comb begin
      state_nx  = state;
      in_brk    = (state == S_BRK_DT) || (state == S_BRK_IDLE);
      set_ok    = r_moe_set & ~r_moe_clr & ~fault_detected;
      rearm     = set_ok | (r_aoe & update_event & ~r_moe_clr & ~fault_detected);
      if (fault_detected && !in_brk) begin
         state_nx = (r_bdt != '0) ? S_BRK_DT : S_BRK_IDLE;
      end else begin
         case (state)
            S_BRK_DT:   if (cnt <= DT_W'(1)) state_nx = S_BRK_IDLE;
            S_BRK_IDLE: if (rearm)           state_nx = S_RUN;
            S_OFF:      if (set_ok)          state_nx = S_RUN;
            S_RUN:      if (r_moe_clr)       state_nx = S_OFF;
            default:                         state_nx = S_OFF;
         endcase
      end
      brk_entry = !in_brk && ((state_nx == S_BRK_DT) || (state_nx == S_BRK_IDLE));
      bif_nx    = brk_entry | (bif & ~r_bif_clr);
   end

   // State, blanking counter and output registers driven from the next state.
   always_ff @(posedge pe_gen_clk) begin
      if (pe_gen_rst) begin
         state            <= S_OFF;
         cnt              <= '0;
         advtmr_oc        <= '0;
         advtmr_ocn       <= '0;
         advtmr_oc_oen    <= '0;
         moe              <= 1'b0;
         bif              <= 1'b0;
         int_status_break <= 1'b0;
      end else begin
         state            <= state_nx;
         bif              <= bif_nx;
         int_status_break <= bif_nx & r_bie;
         if (state_nx == S_BRK_DT && state != S_BRK_DT) begin
            cnt <= r_bdt;
         end else if (state == S_BRK_DT) begin
            cnt <= cnt - DT_W'(1);
         end
         case (state_nx)
            S_RUN: begin
               advtmr_oc     <= pwm_oc;
               advtmr_ocn    <= pwm_ocn;
               advtmr_oc_oen <= '1;
               moe           <= 1'b1;
            end
            S_BRK_DT: begin
               advtmr_oc     <= '0;
               advtmr_ocn    <= '0;
               advtmr_oc_oen <= '1;
               moe           <= 1'b0;
            end
            default: begin
               advtmr_oc     <= r_ossi ? r_ois  : '0;
               advtmr_ocn    <= r_ossi ? r_oisn : '0;
               advtmr_oc_oen <= r_ossi ? '1     : '0;
               moe           <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_break_output_gate.sv
// Directed bench for break_output_gate with hand-computed expectations.
module tb_break_output_gate;

   logic       clk = 1'b0;
   logic       rst;
   logic       fault_detected, update_event, r_moe_set, r_moe_clr, r_aoe, r_ossi;
   logic [2:0] r_ois, r_oisn, pwm_oc, pwm_ocn;
   logic [7:0] r_bdt;
   logic       r_bie, r_bif_clr;
   logic [2:0] advtmr_oc, advtmr_ocn, advtmr_oc_oen;
   logic       moe, bif, int_status_break;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   break_output_gate #(.CH_NUM(3), .DT_W(8)) dut (
      .pe_gen_clk(clk), .pe_gen_rst(rst),
      .fault_detected(fault_detected), .update_event(update_event),
      .r_moe_set(r_moe_set), .r_moe_clr(r_moe_clr), .r_aoe(r_aoe), .r_ossi(r_ossi),
      .r_ois(r_ois), .r_oisn(r_oisn), .r_bdt(r_bdt), .r_bie(r_bie), .r_bif_clr(r_bif_clr),
      .pwm_oc(pwm_oc), .pwm_ocn(pwm_ocn),
      .advtmr_oc(advtmr_oc), .advtmr_ocn(advtmr_ocn), .advtmr_oc_oen(advtmr_oc_oen),
      .moe(moe), .bif(bif), .int_status_break(int_status_break)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_pins(input string tag, input logic [2:0] e_oc, input logic [2:0] e_ocn,
                           input logic [2:0] e_oen, input logic e_moe);
      n_cmp += 4;
      assert (advtmr_oc === e_oc) else begin
         n_mis++; $error("FAIL %s.oc observed=%b expected=%b", tag, advtmr_oc, e_oc);
      end
      assert (advtmr_ocn === e_ocn) else begin
         n_mis++; $error("FAIL %s.ocn observed=%b expected=%b", tag, advtmr_ocn, e_ocn);
      end
      assert (advtmr_oc_oen === e_oen) else begin
         n_mis++; $error("FAIL %s.oen observed=%b expected=%b", tag, advtmr_oc_oen, e_oen);
      end
      assert (moe === e_moe) else begin
         n_mis++; $error("FAIL %s.moe observed=%b expected=%b", tag, moe, e_moe);
      end
   endtask

   task automatic chk_flag(input string tag, input logic e_bif, input logic e_int);
      n_cmp += 2;
      assert (bif === e_bif) else begin
         n_mis++; $error("FAIL %s.bif observed=%b expected=%b", tag, bif, e_bif);
      end
      assert (int_status_break === e_int) else begin
         n_mis++; $error("FAIL %s.int observed=%b expected=%b", tag, int_status_break, e_int);
      end
   endtask

   initial begin
      rst = 1'b1; fault_detected = 1'b0; update_event = 1'b0; r_moe_set = 1'b0;
      r_moe_clr = 1'b0; r_aoe = 1'b0; r_ossi = 1'b0; r_ois = 3'b111; r_oisn = 3'b000;
      r_bdt = 8'd4; r_bie = 1'b1; r_bif_clr = 1'b0; pwm_oc = 3'b101; pwm_ocn = 3'b010;
      tick(); tick();
      chk_pins("reset", 3'b000, 3'b000, 3'b000, 1'b0);
      chk_flag("reset", 1'b0, 1'b0);

      rst = 1'b0;
      tick();
      chk_pins("off_released", 3'b000, 3'b000, 3'b000, 1'b0);

      // Software MOE set, then pass-through latency
      r_moe_set = 1'b1;
      tick();
      r_moe_set = 1'b0;
      chk_pins("moe_set", 3'b101, 3'b010, 3'b111, 1'b1);
      pwm_oc = 3'b011; pwm_ocn = 3'b100;
      chk_pins("pwm_hold", 3'b101, 3'b010, 3'b111, 1'b1);
      tick();
      chk_pins("pwm_follow", 3'b011, 3'b100, 3'b111, 1'b1);

      // Break with 4-cycle blanking, fault held for 10 edges
      r_ossi = 1'b1;
      fault_detected = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_pins("blank", 3'b000, 3'b000, 3'b111, 1'b0);
      end
      chk_flag("brk_flag", 1'b1, 1'b1);
      tick();
      chk_pins("brk_idle", 3'b111, 3'b000, 3'b111, 1'b0);
      r_moe_set = 1'b1;
      tick();
      r_moe_set = 1'b0;
      chk_pins("set_in_fault", 3'b111, 3'b000, 3'b111, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      chk_flag("brk_persist", 1'b1, 1'b1);

      // Automatic re-arm on update_event three cycles after fault drops
      fault_detected = 1'b0; r_aoe = 1'b1;
      tick();
      chk_pins("aoe_wait1", 3'b111, 3'b000, 3'b111, 1'b0);
      tick();
      chk_pins("aoe_wait2", 3'b111, 3'b000, 3'b111, 1'b0);
      update_event = 1'b1;
      tick();
      update_event = 1'b0;
      chk_pins("aoe_rearm", 3'b011, 3'b100, 3'b111, 1'b1);
      pwm_oc = 3'b110; pwm_ocn = 3'b001;
      tick();
      chk_pins("aoe_run", 3'b110, 3'b001, 3'b111, 1'b1);

      // Flag clear alone
      r_bif_clr = 1'b1;
      tick();
      r_bif_clr = 1'b0;
      chk_flag("bif_clr", 1'b0, 1'b0);

      // Re-arm with r_aoe=0 needs software set
      r_aoe = 1'b0; fault_detected = 1'b1;
      tick();
      fault_detected = 1'b0;
      chk_pins("brk2_blank", 3'b000, 3'b000, 3'b111, 1'b0);
      chk_flag("brk2_flag", 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) tick();
      chk_pins("brk2_idle", 3'b111, 3'b000, 3'b111, 1'b0);
      update_event = 1'b1;
      tick();
      update_event = 1'b0;
      chk_pins("noaoe_update", 3'b111, 3'b000, 3'b111, 1'b0);
      r_moe_set = 1'b1;
      tick();
      r_moe_set = 1'b0;
      chk_pins("noaoe_set", 3'b110, 3'b001, 3'b111, 1'b1);

      // Set and clear together: clear wins, off-state drives idle levels
      r_moe_set = 1'b1; r_moe_clr = 1'b1; r_ois = 3'b010; r_oisn = 3'b101;
      tick();
      r_moe_set = 1'b0; r_moe_clr = 1'b0;
      chk_pins("set_clr", 3'b010, 3'b101, 3'b111, 1'b0);

      // Clear colliding with a new break entry: set wins
      r_moe_set = 1'b1;
      tick();
      r_moe_set = 1'b0;
      chk_pins("run3", 3'b110, 3'b001, 3'b111, 1'b1);
      r_bie = 1'b0;
      fault_detected = 1'b1; r_bif_clr = 1'b1;
      tick();
      fault_detected = 1'b0; r_bif_clr = 1'b0;
      chk_flag("clr_vs_set", 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      r_moe_set = 1'b1;
      tick();
      r_moe_set = 1'b0;
      chk_pins("run4", 3'b110, 3'b001, 3'b111, 1'b1);

      // Zero blanking with released pins goes straight to idle
      r_bdt = 8'd0; r_ossi = 1'b0; fault_detected = 1'b1;
      tick();
      fault_detected = 1'b0;
      chk_pins("bdt0_idle", 3'b000, 3'b000, 3'b000, 1'b0);

      // Reset in the middle of blanking
      r_moe_set = 1'b1;
      tick();
      r_moe_set = 1'b0;
      chk_pins("run5", 3'b110, 3'b001, 3'b111, 1'b1);
      r_bdt = 8'd4; r_bie = 1'b1; fault_detected = 1'b1;
      tick();
      chk_pins("brk5_blank", 3'b000, 3'b000, 3'b111, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      chk_pins("mid_reset", 3'b000, 3'b000, 3'b000, 1'b0);
      chk_flag("mid_reset", 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
